// File: rtl/imem_loader_pkg.sv
// Shared constants for the IMem program loader: FSM state encoding, frame start byte
// and the little-endian byte order used to build words and the 16-bit word count.
package imem_loader_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CNT0 = 3'd1;
    localparam logic [2:0] ST_CNT1 = 3'd2;
    localparam logic [2:0] ST_DATA = 3'd3;
    localparam logic [2:0] ST_CSUM = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;
    localparam logic [2:0] ST_ERR  = 3'd6;

    localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;

    // Byte lane that completes a word; lane 0 carries bits 7:0.
    localparam logic [1:0] LANE_LAST = 2'd3;

    // Little-endian assembly: each new byte enters at the top and older bytes move down,
    // so after four bytes the first one received sits in bits 7:0.
    function automatic logic [31:0] shift_in_byte(input logic [31:0] word,
                                                  input logic [7:0]  data);
        return {data, word[31:8]};
    endfunction

    // 16-bit word count, CNT_LO received first.
    function automatic logic [15:0] make_count(input logic [7:0] cnt_hi,
                                               input logic [7:0] cnt_lo);
        return {cnt_hi, cnt_lo};
    endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four data bytes into one 32-bit little-endian word and raises word_valid for
// exactly one cycle after the fourth byte is taken.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        byte_vld,
    input  logic [7:0]  byte_data,
    output logic        lane_last,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    always_comb begin
        lane_d       = lane_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clr) begin
            // Only the lane position restarts; word_q keeps the last word so a pending
            // write strobe still sees valid data.
            lane_d = 2'd0;
        end else if (byte_vld) begin
            word_d = shift_in_byte(word_q, byte_data);
            lane_d = lane_q + 2'd1;
            if (lane_q == LANE_LAST) begin
                word_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_q       <= 2'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign lane_last  = (lane_q == LANE_LAST);
    assign word_valid = word_valid_q;
    assign word       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: parses MAGIC/count/data/checksum frames,
// writes each word as it completes, and holds the core in reset until an image is accepted.
// Define IMEM_LOADER_CSUM_EN to check the trailing checksum byte; otherwise it is ignored.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter logic [7:0] MAGIC  = MAGIC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    logic [2:0]        state_q, state_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic        accept;
    logic [15:0] cnt_new;
    logic        last_word;
    logic        asm_clr;
    logic        asm_byte_vld;
    logic        asm_lane_last;
    logic        asm_word_valid;
    logic [31:0] asm_word;

    assign accept       = rx_valid && rx_ready;
    assign cnt_new      = make_count(rx_data, cnt_lo_q);
    assign last_word    = (({{(32-ADDR_W){1'b0}}, idx_q} + 32'd1) == {16'd0, cnt_q});
    assign asm_clr      = (state_q != ST_DATA);
    assign asm_byte_vld = accept && (state_q == ST_DATA);

    imem_word_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (asm_clr),
        .byte_vld   (asm_byte_vld),
        .byte_data  (rx_data),
        .lane_last  (asm_lane_last),
        .word_valid (asm_word_valid),
        .word       (asm_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_lo_d = cnt_lo_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
`ifdef IMEM_LOADER_CSUM_EN
        sum_d    = sum_q;
`endif
        // The address advances in the cycle its word is written; later clears override.
        if (asm_word_valid) begin
            idx_d = idx_q + ADDR_W'(1);
        end

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (accept && (rx_data == MAGIC)) begin
                    state_d = ST_CNT0;
                    idx_d   = '0;
`ifdef IMEM_LOADER_CSUM_EN
                    sum_d   = 8'd0;
`endif
                end
            end
            ST_CNT0: begin
                if (accept) begin
                    cnt_lo_d = rx_data;
                    state_d  = ST_CNT1;
                end
            end
            ST_CNT1: begin
                if (accept) begin
                    cnt_d = cnt_new;
                    if ({16'd0, cnt_new} > DEPTH) begin
                        state_d = ST_ERR;
                        idx_d   = '0;
`ifdef IMEM_LOADER_CSUM_EN
                        sum_d   = 8'd0;
`endif
                    end else if (cnt_new == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
`ifdef IMEM_LOADER_CSUM_EN
                    sum_d = sum_q + rx_data;
`endif
                    if (asm_lane_last && last_word) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
`ifdef IMEM_LOADER_CSUM_EN
                    if (rx_data == sum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                        idx_d   = '0;
                        sum_d   = 8'd0;
                    end
`else
                    state_d = ST_DONE;
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_lo_q <= 8'd0;
            cnt_q    <= 16'd0;
            idx_q    <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    // Status is decoded from the registered state; the write port comes from the assembler flops.
    assign rx_ready   = (state_q != ST_DONE);
    assign core_hold  = (state_q != ST_DONE);
    assign load_done  = (state_q == ST_DONE);
    assign load_err   = (state_q == ST_ERR);
    assign imem_we    = asm_word_valid;
    assign imem_addr  = idx_q;
    assign imem_wdata = asm_word;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a default-size instance and an ADDR_W=2 instance share
// the byte stream; a negedge monitor logs every IMem write for later comparison.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid_a, rx_valid_b;

    logic        rx_ready_a, we_a, hold_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic        rx_ready_b, we_b, hold_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;

    int checks = 0;
    int errors = 0;
    int sel = 0;

    logic [7:0]  wa_addr[$];
    logic [31:0] wa_data[$];
    logic [1:0]  wb_addr[$];
    logic [31:0] wb_data[$];
    int          dbl_a = 0, dbl_b = 0;
    logic        prev_a = 1'b0, prev_b = 1'b0;

    // 0x13 + 0x93 + 0x10 = 0xB6
    localparam logic [7:0] GOOD_CSUM = 8'hB6;
    logic [7:0] frame_ok [0:10] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                    8'h93, 8'h00, 8'h10, 8'h00};

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(8)) dut_a (
        .clk(clk), .reset(reset), .rx_valid(rx_valid_a), .rx_data(rx_data),
        .rx_ready(rx_ready_a), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .core_hold(hold_a), .load_done(done_a), .load_err(err_a)
    );

    imem_loader #(.ADDR_W(2)) dut_b (
        .clk(clk), .reset(reset), .rx_valid(rx_valid_b), .rx_data(rx_data),
        .rx_ready(rx_ready_b), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .core_hold(hold_b), .load_done(done_b), .load_err(err_b)
    );

    always @(negedge clk) begin
        if (we_a) begin
            wa_addr.push_back(addr_a);
            wa_data.push_back(wdata_a);
        end
        if (we_b) begin
            wb_addr.push_back(addr_b);
            wb_data.push_back(wdata_b);
        end
        if (we_a && prev_a) dbl_a <= dbl_a + 1;
        if (we_b && prev_b) dbl_b <= dbl_b + 1;
        prev_a <= we_a;
        prev_b <= we_b;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        rx_data    = b;
        rx_valid_a = (sel == 0);
        rx_valid_b = (sel == 1);
        @(negedge clk);
        rx_valid_a = 1'b0;
        rx_valid_b = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] csum, input bit gaps);
        for (int i = 0; i < 11; i++) send_byte(frame_ok[i], gaps ? (i % 6) : 0);
        send_byte(csum, gaps ? 5 : 0);
    endtask

    task automatic clear_log();
        wa_addr.delete(); wa_data.delete();
        wb_addr.delete(); wb_data.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_two_words(input string tag);
        checks++;
        if (wa_addr.size() !== 2) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, expected 2", tag, wa_addr.size());
        end else begin
            checks++;
            if (wa_addr[0] !== 8'd0 || wa_data[0] !== 32'h00000013) begin
                errors++;
                $display("FAIL %s_word0: got addr %h data %h, expected 00 00000013", tag, wa_addr[0], wa_data[0]);
            end
            checks++;
            if (wa_addr[1] !== 8'd1 || wa_data[1] !== 32'h00100093) begin
                errors++;
                $display("FAIL %s_word1: got addr %h data %h, expected 01 00100093", tag, wa_addr[1], wa_data[1]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_data = 8'h00; rx_valid_a = 1'b0; rx_valid_b = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({we_a, addr_a, wdata_a, hold_a, done_a, err_a, rx_ready_a} !== {1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_a: got we=%b addr=%h wdata=%h hold=%b done=%b err=%b rdy=%b, expected 0 00 00000000 1 0 0 1",
                     we_a, addr_a, wdata_a, hold_a, done_a, err_a, rx_ready_a);
        end
        checks++;
        if ({we_b, addr_b, hold_b, done_b, err_b, rx_ready_b} !== {1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_b: got we=%b addr=%h hold=%b done=%b err=%b rdy=%b, expected 0 0 1 0 0 1",
                     we_b, addr_b, hold_b, done_b, err_b, rx_ready_b);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        do_reset();
        sel = 0;
        for (int i = 0; i < 7; i++) send_byte(frame_ok[i], 0);
        checks++;
        if (we_a !== 1'b1 || addr_a !== 8'd0 || wdata_a !== 32'h00000013) begin
            errors++;
            $display("FAIL basic_latency: got we=%b addr=%h data=%h, expected 1 00 00000013", we_a, addr_a, wdata_a);
        end
        for (int i = 7; i < 11; i++) send_byte(frame_ok[i], 0);
        checks++;
        if (done_a !== 1'b0 || hold_a !== 1'b1) begin
            errors++;
            $display("FAIL basic_pre_csum: got done=%b hold=%b, expected 0 1", done_a, hold_a);
        end
        send_byte(GOOD_CSUM, 0);
        checks++;
        if ({done_a, hold_a, rx_ready_a, err_a} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_done: got done=%b hold=%b rdy=%b err=%b, expected 1 0 0 0", done_a, hold_a, rx_ready_a, err_a);
        end
        repeat (3) @(negedge clk);
        check_two_words("basic");
    endtask

    task automatic test_bad_csum();
        do_reset();
        sel = 0;
        send_frame(8'h00, 1'b0);
`ifdef IMEM_LOADER_CSUM_EN
        checks++;
        if ({err_a, hold_a, done_a, rx_ready_a} !== 4'b1101) begin
            errors++;
            $display("FAIL badcsum_err: got err=%b hold=%b done=%b rdy=%b, expected 1 1 0 1", err_a, hold_a, done_a, rx_ready_a);
        end
        repeat (2) @(negedge clk);
        check_two_words("badcsum_partial");
        clear_log();
        send_frame(GOOD_CSUM, 1'b0);
        checks++;
        if ({done_a, err_a, hold_a} !== 3'b100) begin
            errors++;
            $display("FAIL badcsum_recover: got done=%b err=%b hold=%b, expected 1 0 0", done_a, err_a, hold_a);
        end
        repeat (2) @(negedge clk);
        check_two_words("badcsum_reload");
`else
        checks++;
        if ({done_a, err_a, hold_a} !== 3'b100) begin
            errors++;
            $display("FAIL csum_ignored: got done=%b err=%b hold=%b, expected 1 0 0", done_a, err_a, hold_a);
        end
        repeat (2) @(negedge clk);
        check_two_words("csum_ignored");
`endif
    endtask

    task automatic test_zero_len();
        do_reset();
        sel = 0;
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (done_a !== 1'b1 || hold_a !== 1'b0 || wa_addr.size() !== 0) begin
            errors++;
            $display("FAIL zero_len: got done=%b hold=%b writes=%0d, expected 1 0 0", done_a, hold_a, wa_addr.size());
        end
    endtask

    task automatic test_noise();
        logic [7:0] noise [0:2] = '{8'h00, 8'hFF, 8'h12};
        do_reset();
        sel = 0;
        for (int i = 0; i < 3; i++) send_byte(noise[i], 1);
        repeat (2) @(negedge clk);
        checks++;
        if ({done_a, err_a, hold_a, rx_ready_a} !== 4'b0011 || wa_addr.size() !== 0) begin
            errors++;
            $display("FAIL noise: got done=%b err=%b hold=%b rdy=%b writes=%0d, expected 0 0 1 1 0",
                     done_a, err_a, hold_a, rx_ready_a, wa_addr.size());
        end
        send_frame(GOOD_CSUM, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL noise_then_frame: got done=%b, expected 1", done_a);
        end
        check_two_words("noise_then_frame");
    endtask

    task automatic test_small_depth();
        do_reset();
        sel = 1;
        send_byte(8'hA5, 0); send_byte(8'h05, 0); send_byte(8'h00, 0);
        checks++;
        if ({err_b, hold_b, done_b, rx_ready_b} !== 4'b1101) begin
            errors++;
            $display("FAIL small_oversize: got err=%b hold=%b done=%b rdy=%b, expected 1 1 0 1", err_b, hold_b, done_b, rx_ready_b);
        end
        send_byte(8'hA5, 0);
        checks++;
        if (err_b !== 1'b0) begin
            errors++;
            $display("FAIL small_err_clear: got err=%b, expected 0", err_b);
        end
        send_byte(8'h04, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 0);
        // 0 + 1 + ... + 15 = 120
        send_byte(8'h78, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (done_b !== 1'b1 || hold_b !== 1'b0) begin
            errors++;
            $display("FAIL small_full_done: got done=%b hold=%b, expected 1 0", done_b, hold_b);
        end
        checks++;
        if (wb_addr.size() !== 4) begin
            errors++;
            $display("FAIL small_full_count: got %0d writes, expected 4", wb_addr.size());
        end else begin
            logic [31:0] exp_w [0:3] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wb_addr[i] !== 2'(i) || wb_data[i] !== exp_w[i]) begin
                    errors++;
                    $display("FAIL small_full_word%0d: got addr %h data %h, expected %h %h", i, wb_addr[i], wb_data[i], 2'(i), exp_w[i]);
                end
            end
        end
        checks++;
        if (wa_addr.size() !== 0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL small_isolation: got writes_a=%0d done_a=%b, expected 0 0", wa_addr.size(), done_a);
        end
        sel = 0;
    endtask

    task automatic test_gaps();
        do_reset();
        sel = 0;
        send_frame(GOOD_CSUM, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL gaps_done: got done=%b, expected 1", done_a);
        end
        check_two_words("gaps");
    endtask

    task automatic test_reset_mid();
        do_reset();
        sel = 0;
        for (int i = 0; i < 9; i++) send_byte(frame_ok[i], 0);
        checks++;
        if (addr_a !== 8'd1) begin
            errors++;
            $display("FAIL midreset_pre_addr: got addr=%h, expected 01", addr_a);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({we_a, addr_a, wdata_a, hold_a, done_a, err_a, rx_ready_a} !== {1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midreset_async: got we=%b addr=%h wdata=%h hold=%b done=%b err=%b rdy=%b, expected 0 00 00000000 1 0 0 1",
                     we_a, addr_a, wdata_a, hold_a, done_a, err_a, rx_ready_a);
        end
        @(negedge clk);
        clear_log();
        reset = 1'b1;
        @(negedge clk);
        send_frame(GOOD_CSUM, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reload_done: got done=%b, expected 1", done_a);
        end
        check_two_words("midreset_reload");
    endtask

    task automatic test_single_strobe();
        checks++;
        if (dbl_a !== 0 || dbl_b !== 0) begin
            errors++;
            $display("FAIL single_strobe: got back-to-back strobes a=%0d b=%0d, expected 0 0", dbl_a, dbl_b);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_bad_csum();
        test_zero_len();
        test_noise();
        test_small_depth();
        test_gaps();
        test_reset_mid();
        test_single_strobe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
